// File: rtl/pulse_former_pkg.sv
// Shared definitions for the pulse former: FSM state encoding and default counter width.
package pulse_former_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/pf_down_counter.sv
// Saturating down-counter with synchronous load; zero flag reflects the current count.
module pf_down_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  // Load wins over decrement; the count holds at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/pulse_former.sv
// Trigger-to-pulse shaper: programmable delay, programmable width, optional retrigger.
module pulse_former
  import pulse_former_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  input  logic             retrig_en,
  output logic             q,
  output logic             busy,
  output logic             done,
  output logic             missed
);

  state_t           state_reg;
  logic [CNT_W-1:0] width_lat_reg;

  logic             d_load;
  logic             d_zero;
  logic [CNT_W-1:0] d_val;
  logic             w_load;
  logic             w_zero;
  logic [CNT_W-1:0] w_val;
  logic [CNT_W-1:0] width_m1;
  logic [CNT_W-1:0] width_lat_m1;

  // Counters hold "remaining cycles minus one"; a width of zero behaves as one.
  assign width_m1     = (width == '0) ? '0 : width - CNT_W'(1);
  assign width_lat_m1 = (width_lat_reg == '0) ? '0 : width_lat_reg - CNT_W'(1);

  always_comb begin
    d_load = 1'b0;
    d_val  = delay - CNT_W'(1);
    w_load = 1'b0;
    w_val  = width_m1;
    case (state_reg)
      IDLE: begin
        if (trig) begin
          if (delay == '0) begin
            w_load = 1'b1;
          end else begin
            d_load = 1'b1;
          end
        end
      end
      DELAY: begin
        if (d_zero) begin
          w_load = 1'b1;
          w_val  = width_lat_m1;
        end
      end
      ACTIVE: begin
        if (trig && retrig_en) begin
          w_load = 1'b1;
        end
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  pf_down_counter #(.CNT_W(CNT_W)) u_delay_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (d_load),
    .enable   (state_reg == DELAY),
    .load_val (d_val),
    .zero     (d_zero)
  );

  pf_down_counter #(.CNT_W(CNT_W)) u_width_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .enable   (state_reg == ACTIVE),
    .load_val (w_val),
    .zero     (w_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      width_lat_reg <= '0;
      q             <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      missed        <= 1'b0;
    end else begin
      done   <= 1'b0;
      missed <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (trig) begin
            width_lat_reg <= width;
            busy          <= 1'b1;
            if (delay == '0) begin
              state_reg <= ACTIVE;
              q         <= 1'b1;
            end else begin
              state_reg <= DELAY;
            end
          end
        end
        DELAY: begin
          if (trig) begin
            missed <= 1'b1;
          end
          if (d_zero) begin
            state_reg <= ACTIVE;
            q         <= 1'b1;
          end
        end
        ACTIVE: begin
          // A retrigger reloads the width counter and keeps q high, even on the last edge.
          if (!(trig && retrig_en)) begin
            if (trig) begin
              missed <= 1'b1;
            end
            if (w_zero) begin
              state_reg <= IDLE;
              q         <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          q         <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_former.sv
// Directed cycle-by-cycle vectors for pulse_former (CNT_W=4) plus max-count sequences.
module tb_pulse_former;

  logic       clk;
  logic       reset;
  logic       trig;
  logic [3:0] delay;
  logic [3:0] width;
  logic       retrig_en;
  logic       q;
  logic       busy;
  logic       done;
  logic       missed;

  int total;
  int bad;

  pulse_former #(.CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .trig      (trig),
    .delay     (delay),
    .width     (width),
    .retrig_en (retrig_en),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .missed    (missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp = {q, busy, done, missed} after the edge that samples the inputs
  typedef struct {
    string      name;
    logic       rst;
    logic       trg;
    logic       ret;
    logic [3:0] dly;
    logic [3:0] wid;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, logic r, logic t, logic rt,
                              logic [3:0] d, logic [3:0] w, logic [3:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.trg = t; v.ret = rt;
    v.dly = d; v.wid = w; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic check(string n, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  initial begin
    int hi;
    int lo;
    bit ended;
    total = 0;
    bad = 0;
    reset = 1'b1; trig = 1'b0; delay = '0; width = '0; retrig_en = 1'b0;

    // reset, with a trigger that must be discarded
    add("rst_trig", 1, 1, 0, 0, 3, 4'b0000);
    add("rst",      1, 0, 0, 0, 0, 4'b0000);
    add("idle",     0, 0, 0, 0, 0, 4'b0000);
    // D=0 W=3; width change after latching has no effect
    add("d0w3_e0",  0, 1, 0, 0, 3, 4'b1100);
    add("d0w3_e1",  0, 0, 0, 0, 7, 4'b1100);
    add("d0w3_e2",  0, 0, 0, 0, 7, 4'b1100);
    add("d0w3_e3",  0, 0, 0, 0, 7, 4'b0010);
    add("d0w3_e4",  0, 0, 0, 0, 7, 4'b0000);
    // D=4 W=2; delay change after latching has no effect
    add("d4w2_e0",  0, 1, 0, 4, 2, 4'b0100);
    add("d4w2_e1",  0, 0, 0, 9, 9, 4'b0100);
    add("d4w2_e2",  0, 0, 0, 9, 9, 4'b0100);
    add("d4w2_e3",  0, 0, 0, 9, 9, 4'b0100);
    add("d4w2_e4",  0, 0, 0, 9, 9, 4'b1100);
    add("d4w2_e5",  0, 0, 0, 9, 9, 4'b1100);
    add("d4w2_e6",  0, 0, 0, 9, 9, 4'b0010);
    add("d4w2_e7",  0, 0, 0, 9, 9, 4'b0000);
    // D=2 W=5, second trigger in DELAY is missed
    add("dly_miss_e0", 0, 1, 0, 2, 5, 4'b0100);
    add("dly_miss_e1", 0, 1, 0, 2, 1, 4'b0101);
    add("dly_miss_e2", 0, 0, 0, 2, 1, 4'b1100);
    add("dly_miss_e3", 0, 0, 0, 2, 1, 4'b1100);
    add("dly_miss_e4", 0, 0, 0, 2, 1, 4'b1100);
    add("dly_miss_e5", 0, 0, 0, 2, 1, 4'b1100);
    add("dly_miss_e6", 0, 0, 0, 2, 1, 4'b1100);
    add("dly_miss_e7", 0, 0, 0, 2, 1, 4'b0010);
    add("dly_miss_e8", 0, 0, 0, 2, 1, 4'b0000);
    // retrigger enabled: W=4, retrig at start of 3rd high cycle with W=4 -> 6 high
    add("retrig_e0", 0, 1, 1, 0, 4, 4'b1100);
    add("retrig_e1", 0, 0, 1, 0, 4, 4'b1100);
    add("retrig_e2", 0, 1, 1, 0, 4, 4'b1100);
    add("retrig_e3", 0, 0, 1, 0, 4, 4'b1100);
    add("retrig_e4", 0, 0, 1, 0, 4, 4'b1100);
    add("retrig_e5", 0, 0, 1, 0, 4, 4'b1100);
    add("retrig_e6", 0, 0, 1, 0, 4, 4'b0010);
    add("retrig_e7", 0, 0, 1, 0, 4, 4'b0000);
    // same stimulus, retrigger disabled -> 4 high, missed
    add("noretrig_e0", 0, 1, 0, 0, 4, 4'b1100);
    add("noretrig_e1", 0, 0, 0, 0, 4, 4'b1100);
    add("noretrig_e2", 0, 1, 0, 0, 4, 4'b1101);
    add("noretrig_e3", 0, 0, 0, 0, 4, 4'b1100);
    add("noretrig_e4", 0, 0, 0, 0, 4, 4'b0010);
    add("noretrig_e5", 0, 0, 0, 0, 4, 4'b0000);
    // reset in 2nd ACTIVE cycle of W=10, then a normal D=1 W=2 pulse
    add("rst_act_e0", 0, 1, 0, 0, 10, 4'b1100);
    add("rst_act_e1", 1, 0, 0, 0, 10, 4'b0000);
    add("rst_act_e2", 0, 0, 0, 0, 10, 4'b0000);
    add("after_rst_e0", 0, 1, 0, 1, 2, 4'b0100);
    add("after_rst_e1", 0, 0, 0, 1, 2, 4'b1100);
    add("after_rst_e2", 0, 0, 0, 1, 2, 4'b1100);
    add("after_rst_e3", 0, 0, 0, 1, 2, 4'b0010);
    add("after_rst_e4", 0, 0, 0, 1, 2, 4'b0000);
    // W=0 behaves as W=1
    add("w0_e0", 0, 1, 0, 0, 0, 4'b1100);
    add("w0_e1", 0, 0, 0, 0, 0, 4'b0010);
    add("w0_e2", 0, 0, 0, 0, 0, 4'b0000);
    // retrigger on the final ACTIVE edge extends, no done
    add("fin_ret_e0", 0, 1, 1, 0, 2, 4'b1100);
    add("fin_ret_e1", 0, 0, 1, 0, 2, 4'b1100);
    add("fin_ret_e2", 0, 1, 1, 0, 3, 4'b1100);
    add("fin_ret_e3", 0, 0, 1, 0, 3, 4'b1100);
    add("fin_ret_e4", 0, 0, 1, 0, 3, 4'b1100);
    add("fin_ret_e5", 0, 0, 1, 0, 3, 4'b0010);
    add("fin_ret_e6", 0, 0, 1, 0, 3, 4'b0000);
    // trigger on the final ACTIVE edge without retrigger: missed and done together
    add("fin_miss_e0", 0, 1, 0, 0, 2, 4'b1100);
    add("fin_miss_e1", 0, 0, 0, 0, 2, 4'b1100);
    add("fin_miss_e2", 0, 1, 0, 0, 2, 4'b0011);
    add("fin_miss_e3", 0, 0, 0, 0, 2, 4'b0000);
    // trigger during the done cycle is accepted -> one-cycle gap
    add("gap_e0", 0, 1, 0, 0, 1, 4'b1100);
    add("gap_e1", 0, 0, 0, 0, 1, 4'b0010);
    add("gap_e2", 0, 1, 0, 0, 1, 4'b1100);
    add("gap_e3", 0, 0, 0, 0, 1, 4'b0010);
    add("gap_e4", 0, 0, 0, 0, 1, 4'b0000);
    // reset during DELAY
    add("rst_dly_e0", 0, 1, 0, 3, 2, 4'b0100);
    add("rst_dly_e1", 1, 0, 0, 3, 2, 4'b0000);
    add("rst_dly_e2", 0, 0, 0, 3, 2, 4'b0000);
    add("rst_dly_e3", 0, 0, 0, 3, 2, 4'b0000);
    // trigger on the DELAY->ACTIVE edge is missed
    add("dly_edge_e0", 0, 1, 0, 1, 1, 4'b0100);
    add("dly_edge_e1", 0, 1, 0, 1, 1, 4'b1101);
    add("dly_edge_e2", 0, 0, 0, 1, 1, 4'b0010);
    add("dly_edge_e3", 0, 0, 0, 1, 1, 4'b0000);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; trig = vecs[i].trg; retrig_en = vecs[i].ret;
      delay = vecs[i].dly; width = vecs[i].wid;
      @(posedge clk);
      #1;
      $display("vec %0d %s q=%b busy=%b done=%b missed=%b", i, vecs[i].name, q, busy, done, missed);
      check(vecs[i].name, int'({q, busy, done, missed}), int'(vecs[i].exp));
    end

    // W=15 (maximum at CNT_W=4), D=0: exactly 15 high cycles then done
    @(negedge clk);
    reset = 1'b0; trig = 1'b1; retrig_en = 1'b0; delay = 4'd0; width = 4'd15;
    @(posedge clk); #1;
    trig = 1'b0;
    hi = 0; ended = 0;
    for (int i = 0; i < 40; i++) begin
      if (q) begin
        hi++;
      end else begin
        ended = 1;
        break;
      end
      @(posedge clk); #1;
    end
    $display("seq w15 high=%0d done=%b", hi, done);
    check("w15_ended", int'(ended), 1);
    check("w15_high", hi, 15);
    check("w15_done", int'(done), 1);
    @(posedge clk); #1;
    check("w15_idle", int'({q, busy, done}), 0);

    // D=15 (maximum), W=1: 15 low busy cycles, then 1 high cycle
    @(negedge clk);
    trig = 1'b1; delay = 4'd15; width = 4'd1;
    @(posedge clk); #1;
    trig = 1'b0;
    lo = 0; ended = 0;
    for (int i = 0; i < 40; i++) begin
      if (q) begin
        ended = 1;
        break;
      end
      if (busy) lo++;
      @(posedge clk); #1;
    end
    $display("seq d15 low=%0d", lo);
    check("d15_reached", int'(ended), 1);
    check("d15_low", lo, 15);
    @(posedge clk); #1;
    check("d15_w1_end", int'({q, busy, done}), 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_former.md
PULSE_FORMER -- requirements
Module: pulse_former

Interface
REQ-001 Parameter CNT_W, default 16, width of the delay and width counters and their inputs.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 trig  input  1  single-cycle trigger strobe; sampled on every rising edge of clk.
REQ-005 delay  input  CNT_W  trigger-to-output delay in clk cycles; latched on trigger acceptance.
REQ-006 width  input  CNT_W  output pulse length in clk cycles; latched on acceptance or retrigger.
REQ-007 retrig_en  input  1  1: a trigger during ACTIVE restarts the width count.
REQ-008 q  output  1  shaped output level; registered.
REQ-009 busy  output  1  high whenever state is not IDLE; registered.
REQ-010 done  output  1  one-cycle pulse in the first cycle q is low after a pulse ends.
REQ-011 missed  output  1  one-cycle pulse when a trigger is ignored.

Function
REQ-012 The FSM SHALL have three states: IDLE, DELAY, ACTIVE.
REQ-013 trig high at edge E0 in IDLE SHALL be accepted: delay and width latched, busy=1 after E0.
REQ-014 If latched delay D=0, the FSM SHALL go IDLE->ACTIVE at E0 and q SHALL be 1 from E0.
REQ-015 If D>0, the FSM SHALL go IDLE->DELAY at E0 and DELAY->ACTIVE at edge E0+D, with q=1 from E0+D.
REQ-016 Latched width W=0 SHALL be treated as W=1.
REQ-017 q SHALL stay 1 for exactly W cycles; at the edge ending the last high cycle the FSM SHALL go ACTIVE->IDLE, with q=0, busy=0 and done=1 for one cycle.
REQ-018 trig during DELAY SHALL be ignored, with missed=1 for the following cycle; the delay count SHALL continue unchanged.
REQ-019 trig during ACTIVE with retrig_en=0 SHALL be ignored, with missed=1 for one cycle.
REQ-020 trig at edge Ek during ACTIVE with retrig_en=1 SHALL relatch width W2 and keep q=1 without a gap, with q=0 after edge Ek+W2; missed SHALL stay 0.
REQ-021 If trig coincides with the final ACTIVE edge and retrig_en=1, the pulse SHALL be extended per REQ-020, with no done pulse.
REQ-022 If trig coincides with the final ACTIVE edge and retrig_en=0, the trigger SHALL be missed (missed=1) and done=1.
REQ-023 trig in the cycle where done=1 (state IDLE) SHALL be accepted normally, giving a q low gap of exactly 1 cycle (D=0).
REQ-024 Changes to delay and width after latching SHALL NOT affect the pulse in progress.
REQ-025 Counters SHALL be down-counters of CNT_W bits, never wrapping; the maximum delay and width SHALL be 2^CNT_W-1.

Reset
REQ-026 While reset=1 at a clk edge: state=IDLE, q=0, busy=0, done=0, missed=0, counters=0.
REQ-027 Reset SHALL take priority over trig in the same cycle; that trigger SHALL be discarded with no missed pulse.
REQ-028 Reset during DELAY or ACTIVE SHALL force q=0 after that edge, with no done pulse.

Structure
REQ-029 Package pulse_former_pkg SHALL hold the state enum typedef (IDLE, DELAY, ACTIVE) and the default CNT_W constant.
REQ-030 One sub-module, pf_down_counter (load, enable, zero flag, CNT_W wide), SHALL be instantiated twice: delay counter and width counter.

Verification
REQ-031 D=0, W=3, trig at E0: q=1 for cycles E0..E2, done=1 and busy=0 after E3.
REQ-032 D=4, W=2: q=0 for 4 cycles after E0, then q=1 for 2 cycles, then done=1 for 1 cycle.
REQ-033 D=2, W=5, second trig 1 cycle after the first: missed=1 for one cycle, and the timing matches a single trigger.
REQ-034 retrig_en=1, W=4, second trig at the 3rd high cycle with W=4: total q high = 6 cycles, one done pulse; the same stimulus with retrig_en=0 gives 4 cycles and missed=1.
REQ-035 Reset asserted in the 2nd ACTIVE cycle of W=10: q=0 and busy=0 after that edge, no done pulse, and the next trig behaves normally.
REQ-036 W=0, D=0, and W=2^CNT_W-1 with CNT_W=4 (W=15): q high 1 and 15 cycles respectively, with no counter wrap.
